// File: rtl/pn_pkg.sv
// pn_pkg -- shared definitions for the PN frame sequencer.
//   state_e        : frame sequencer states
//   BT_*           : bit_type encodings driven on the output stream
//   PN_LFSR_W      : LFSR register width
//   TAP_*          : feedback tap positions (fb = s[9]^s[5]^s[0])
//   CNT_W          : width of the per-section transfer counter
package pn_pkg;

  localparam int PN_LFSR_W = 10;
  localparam int TAP_HI    = 9;
  localparam int TAP_MID   = 5;
  localparam int TAP_LO    = 0;
  localparam int CNT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PRE   = 3'd2,
    ST_PAY   = 3'd3,
    ST_GUARD = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [1:0] BT_IDLE  = 2'd0;
  localparam logic [1:0] BT_PRE   = 2'd1;
  localparam logic [1:0] BT_PAY   = 2'd2;
  localparam logic [1:0] BT_GUARD = 2'd3;

endpackage

// File: rtl/pn_lfsr.sv
// pn_lfsr -- Fibonacci LFSR with synchronous load and shift enable.
// A zero seed is replaced by 1 on load so the register can never lock up.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (register resets to 1)
//   load_i     : load seed_i (takes priority over shift_i)
//   seed_i     : seed value
//   shift_i    : advance one step
//   chip_o     : current output chip, s[0]
module pn_lfsr
  import pn_pkg::*;
#(
  parameter int LFSR_W = PN_LFSR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              shift_i,
  output logic              chip_o
);

  localparam logic [LFSR_W-1:0] LFSR_ONE = {{(LFSR_W-1){1'b0}}, 1'b1};

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Next-state: load wins over shift; otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == '0) ? LFSR_ONE : seed_i;
    end else if (shift_i) begin
      lfsr_d = {lfsr_q[TAP_HI] ^ lfsr_q[TAP_MID] ^ lfsr_q[TAP_LO], lfsr_q[LFSR_W-1:1]};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_ONE;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign chip_o = lfsr_q[0];

endmodule

// File: rtl/pn_frame_ctrl.sv
// pn_frame_ctrl -- frame sequencer for the PN test transmitter.
// Emits one frame per start: PRE_LEN LFSR preamble chips, PAY_LEN payload
// bits forwarded from upstream, then GUARD_LEN zeros, on a valid/ready stream.
// Build option: `define PN_SCRAMBLE_EN to XOR payload bits with the LFSR chip
// stream, which keeps running through the payload.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start, seed           : frame request (IDLE only) and LFSR seed
//   abort                 : drop the frame, IDLE next cycle, no done
//   pay_bit/valid/ready   : upstream payload bit stream
//   bit_o/valid/ready     : downstream bit stream
//   bit_type              : 0 idle, 1 preamble, 2 payload, 3 guard
//   busy, done            : not-IDLE flag, one-cycle completion pulse
module pn_frame_ctrl
  import pn_pkg::*;
#(
  parameter int LFSR_W    = PN_LFSR_W,
  parameter int PRE_LEN   = 31,
  parameter int PAY_LEN   = 64,
  parameter int GUARD_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [LFSR_W-1:0] seed,
  input  logic              pay_bit,
  input  logic              pay_valid,
  output logic              pay_ready,
  output logic              bit_o,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic [1:0]        bit_type,
  output logic              busy,
  output logic              done
);

  // Counters compare against length-1 so the last transfer of a section is
  // recognised in the same cycle it happens.
  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] PAY_LAST   = CNT_W'(PAY_LEN - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_LEN > 0) ? (GUARD_LEN - 1) : 0);
  localparam bit               SKIP_GUARD = (GUARD_LEN == 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LFSR_W-1:0] seed_q, seed_d;
  logic              lfsr_load_s;
  logic              lfsr_shift_s;
  logic              chip_s;

  pn_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load_i  (lfsr_load_s),
    .seed_i  (seed_q),
    .shift_i (lfsr_shift_s),
    .chip_o  (chip_s)
  );

  // Next-state, counter, LFSR control and stream outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    seed_d       = seed_q;
    lfsr_load_s  = 1'b0;
    lfsr_shift_s = 1'b0;
    pay_ready    = 1'b0;
    bit_o        = 1'b0;
    bit_valid    = 1'b0;
    bit_type     = BT_IDLE;
    busy         = 1'b1;
    done         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = ST_LOAD;
          seed_d  = seed;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        lfsr_load_s = 1'b1;
        cnt_d       = '0;
        state_d     = ST_PRE;
      end

      ST_PRE: begin
        bit_valid = 1'b1;
        bit_o     = chip_s;
        bit_type  = BT_PRE;
        if (bit_ready) begin
          lfsr_shift_s = 1'b1;
          if (cnt_q == PRE_LAST) begin
            cnt_d   = '0;
            state_d = ST_PAY;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      ST_PAY: begin
        bit_valid = pay_valid;
        pay_ready = bit_ready;
        bit_type  = BT_PAY;
`ifdef PN_SCRAMBLE_EN
        bit_o = pay_bit ^ chip_s;
`else
        bit_o = pay_bit;
`endif
        if (pay_valid && bit_ready) begin
`ifdef PN_SCRAMBLE_EN
          lfsr_shift_s = 1'b1;
`else
          lfsr_shift_s = 1'b0;
`endif
          if (cnt_q == PAY_LAST) begin
            cnt_d   = '0;
            state_d = SKIP_GUARD ? ST_DONE : ST_GUARD;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      ST_GUARD: begin
        bit_valid = 1'b1;
        bit_o     = 1'b0;
        bit_type  = BT_GUARD;
        if (bit_ready) begin
          if (cnt_q == GUARD_LAST) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        busy    = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides every transition, including a start seen in IDLE.
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      state_d = state_d;
    end
  end

  // State, counter and captured-seed registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
    end
  end

endmodule

// File: tb/tb_pn_frame_ctrl.sv
// tb_pn_frame_ctrl -- randomized self-checking bench for pn_frame_ctrl.
// Each frame's expected bit stream is computed up front from the frame rules
// (preamble from an arithmetic LFSR model, payload from a random queue, guard
// zeros) and compared transfer by transfer against the DUT under random
// backpressure, gapped upstream data, stray starts and an abort.
module tb_pn_frame_ctrl;

  localparam int PRE_LEN   = 31;
  localparam int PAY_LEN   = 64;
  localparam int GUARD_LEN = 4;
  localparam int TOTAL     = PRE_LEN + PAY_LEN + GUARD_LEN;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [9:0] seed;
  logic       pay_bit;
  logic       pay_valid;
  logic       pay_ready;
  logic       bit_o;
  logic       bit_valid;
  logic       bit_ready;
  logic [1:0] bit_type;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pn_frame_ctrl #(
    .LFSR_W    (10),
    .PRE_LEN   (PRE_LEN),
    .PAY_LEN   (PAY_LEN),
    .GUARD_LEN (GUARD_LEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .seed      (seed),
    .pay_bit   (pay_bit),
    .pay_valid (pay_valid),
    .pay_ready (pay_ready),
    .bit_o     (bit_o),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .bit_type  (bit_type),
    .busy      (busy),
    .done      (done)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One step of the x^9+x^5+1 sequence on a plain integer.
  function automatic int pn_step(input int s);
    int fb;
    fb = ((s >> 9) ^ (s >> 5) ^ s) & 1;
    return (s >> 1) | (fb << 9);
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_valid"}, int'(bit_valid), 0);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_done"}, int'(done), 0);
    check_eq({tag, "_pay_ready"}, int'(pay_ready), 0);
    check_eq({tag, "_type"}, int'(bit_type), 0);
    check_eq({tag, "_bit"}, int'(bit_o), 0);
  endtask

  // Runs one frame. Entered and left at posedge+1 with the DUT idle-able.
  // abort_pay >= 0 aborts on the payload transfer with that index.
  task automatic run_frame(input logic [9:0] sd, input int rdy_pct, input bit gap,
                           input int abort_pay, input bit zero_pay, input bit first_frame);
    int s, idx, pidx, cyc, budget, n_pre, n_pay, n_grd, n_chip;
    bit exp_b[$];
    int exp_t[$];
    bit pay_q[$];
    bit in_pay, aborting, exp_v, xfer, stalled, b;
    logic [3:0] first_chips;
    logic [3:0] golden_head;

    // Build the expected stream for this frame.
    s = (sd == 10'd0) ? 1 : int'(sd);
    for (int i = 0; i < PRE_LEN; i++) begin
      exp_b.push_back(bit'(s & 1));
      exp_t.push_back(1);
      s = pn_step(s);
    end
    for (int j = 0; j < PAY_LEN; j++) begin
      b = zero_pay ? 1'b0 : 1'($urandom_range(1));
      pay_q.push_back(b);
`ifdef PN_SCRAMBLE_EN
      exp_b.push_back(b ^ bit'(s & 1));
      s = pn_step(s);
`else
      exp_b.push_back(b);
`endif
      exp_t.push_back(2);
    end
    for (int k = 0; k < GUARD_LEN; k++) begin
      exp_b.push_back(1'b0);
      exp_t.push_back(3);
    end

    // Start cycle: DUT still idle.
    start     = 1'b1;
    seed      = sd;
    abort     = 1'b0;
    bit_ready = 1'($urandom_range(1));
    pay_valid = 1'($urandom_range(1));
    pay_bit   = 1'($urandom_range(1));
    @(negedge clk);
    check_idle("idle_at_start");
    @(posedge clk); #1;
    start = 1'b0;
    seed  = 10'($urandom);
    @(negedge clk);
    check_eq("load_busy", int'(busy), 1);
    check_eq("load_valid", int'(bit_valid), 0);
    @(posedge clk); #1;

    idx = 0; pidx = 0; cyc = 0; stalled = 1'b0;
    n_pre = 0; n_pay = 0; n_grd = 0; n_chip = 0;
    first_chips = 4'd0;
    budget = TOTAL * 30 + 100;
    while (idx < TOTAL && cyc < budget) begin
      in_pay   = (idx >= PRE_LEN) && (idx < PRE_LEN + PAY_LEN);
      aborting = in_pay && (pidx == abort_pay);
      bit_ready = ($urandom_range(99) < rdy_pct);
      if (in_pay) begin
        if (!stalled) pay_valid = gap ? ((cyc % 3) != 2) : 1'b1;
        pay_bit = pay_valid ? pay_q[pidx] : 1'($urandom_range(1));
      end else begin
        pay_valid = 1'($urandom_range(1));
        pay_bit   = 1'($urandom_range(1));
      end
      start = ($urandom_range(7) == 0);
      seed  = 10'($urandom);
      if (aborting) begin
        abort     = 1'b1;
        start     = 1'b1;
        bit_ready = 1'b1;
        pay_valid = 1'b1;
        pay_bit   = pay_q[pidx];
      end
      @(negedge clk);
      exp_v = in_pay ? pay_valid : 1'b1;
      check_eq("bit_valid", int'(bit_valid), int'(exp_v));
      check_eq("busy", int'(busy), 1);
      check_eq("done_early", int'(done), 0);
      check_eq("pay_ready", int'(pay_ready), in_pay ? int'(bit_ready) : 0);
      if (exp_v) begin
        check_eq("bit_type", int'(bit_type), exp_t[idx]);
        check_eq("bit_o", int'(bit_o), int'(exp_b[idx]));
      end
      xfer    = exp_v && bit_ready;
      stalled = in_pay && exp_v && !bit_ready;
      if (xfer && first_frame) begin
        if (bit_type == 2'd1) begin
          if (n_chip < 4) first_chips[3 - n_chip] = bit_o;
          n_chip++;
          n_pre++;
        end else if (bit_type == 2'd2) begin
          n_pay++;
        end else if (bit_type == 2'd3) begin
          n_grd++;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (xfer) begin
        if (in_pay) pidx++;
        idx++;
      end
      if (aborting) begin
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle("after_abort");
        @(posedge clk); #1;
        return;
      end
    end

    check_eq("frame_complete", idx, TOTAL);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_eq("done_pulse", int'(done), 1);
    check_eq("done_busy", int'(busy), 1);
    check_eq("done_valid", int'(bit_valid), 0);
    check_eq("done_pay_ready", int'(pay_ready), 0);
    if (first_frame) begin
      golden_head = 4'b1000;
      check_eq("first_chips", int'(first_chips), int'(golden_head));
      check_eq("n_pre", n_pre, PRE_LEN);
      check_eq("n_pay", n_pay, PAY_LEN);
      check_eq("n_guard", n_grd, GUARD_LEN);
      check_eq("frame_cycles", cyc, TOTAL);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    seed      = 10'd0;
    pay_bit   = 1'b0;
    pay_valid = 1'b0;
    bit_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    run_frame(10'h001, 100, 1'b0, -1, 1'b0, 1'b1);
    run_frame(10'h000, 100, 1'b0, -1, 1'b0, 1'b0);
    run_frame(10'($urandom), 50, 1'b1, -1, 1'b0, 1'b0);
    run_frame(10'($urandom), 70, 1'b1, 10, 1'b0, 1'b0);
    run_frame(10'($urandom), 60, 1'b0, -1, 1'b1, 1'b0);
    for (int f = 0; f < 3; f++) begin
      run_frame(10'($urandom), 40 + 20 * f, 1'(f & 1), -1, 1'b0, 1'b0);
    end

    @(negedge clk);
    check_idle("final_idle");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pn_frame_ctrl.md
# pn_frame_ctrl

Frame sequencer for the PN test transmitter. It loads a seed into a 10-bit Fibonacci LFSR (x^9+x^5+1 style tap set). It then emits one frame on a valid/ready bit stream: a PN preamble, a payload forwarded from an upstream bit source, and a zero guard interval. It sits between the payload source and the modulator, and owns all LFSR sequencing.

## Interface
- LFSR_W, 10, LFSR register width; feedback = s[9]^s[5]^s[0], shift = {fb, s[LFSR_W-1:1]}, chip = s[0]
- PRE_LEN, 31, preamble chips per frame (1..1023)
- PAY_LEN, 64, payload bits per frame (1..65535)
- GUARD_LEN, 4, guard zeros per frame (0..255; 0 skips GUARD)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  frame request; sampled only in IDLE
- abort  in  1  terminate current frame; enter IDLE next cycle
- seed  in  LFSR_W  LFSR seed captured at start
- pay_bit  in  1  upstream payload bit
- pay_valid  in  1  upstream bit valid
- pay_ready  out  1  upstream bit accepted when pay_valid&&pay_ready
- bit_o  out  1  output bit
- bit_valid  out  1  bit_o valid
- bit_ready  in  1  downstream accept; transfer = bit_valid&&bit_ready
- bit_type  out  2  0 idle, 1 preamble, 2 payload, 3 guard
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on frame completion (not on abort)

## Operation
- States: IDLE, LOAD, PRE, PAY, GUARD, DONE.
- IDLE: all outputs 0.
  - start=1 -> LOAD; seed is captured. seed==0 is replaced by 1, so the LFSR never locks up.
- LOAD: one cycle. LFSR <= captured seed, count <= 0 -> PRE.
- PRE:
  - bit_valid=1, bit_o=s[0], bit_type=1.
  - On each transfer: LFSR shifts and count increments.
  - After the PRE_LEN-th transfer -> PAY, count <= 0.
- PAY:
  - bit_valid=pay_valid, pay_ready=bit_ready, bit_o=pay_bit (combinational pass-through), bit_type=2.
  - Each transfer counts.
  - After PAY_LEN transfers -> GUARD, or -> DONE if GUARD_LEN==0.
- GUARD:
  - bit_valid=1, bit_o=0, bit_type=3.
  - After GUARD_LEN transfers -> DONE.
- DONE: done=1 for one cycle, busy=1 -> IDLE.
- pay_ready=0 in every state except PAY.
- abort:
  - Has priority over every transition and over start. Any state -> IDLE next cycle, no done pulse.
  - A transfer in the abort cycle still completes on the interface.
- start while busy: ignored, not queued.
- Counter: 16-bit, compared against the length of the current state.

## Timing
- Reset: state IDLE, LFSR = 1, counter 0; all outputs 0.
- start at edge n -> LOAD in cycle n+1 -> first preamble chip valid in cycle n+2.
- Back-to-back transfers: 1 bit/cycle in all states; frame length = PRE_LEN+PAY_LEN+GUARD_LEN transfers.
- Stall rule: while bit_valid&&!bit_ready, bit_o and bit_type hold stable and the LFSR/counter hold. In PAY, stability is the upstream's obligation.
- Minimum IDLE gap between frames: one cycle (DONE -> IDLE -> start).

## Configuration
- PN_SCRAMBLE_EN defined:
  - In PAY, bit_o = pay_bit ^ s[0].
  - The LFSR keeps running from its end-of-preamble state and shifts on each payload transfer.
- PN_SCRAMBLE_EN undefined:
  - Payload passes unmodified; the LFSR holds during PAY.
- All other behaviour is identical in both builds.

## Structure
- Shared package pn_pkg:
  - state enum
  - bit_type encodings (BT_IDLE/BT_PRE/BT_PAY/BT_GUARD)
  - LFSR tap constants
  - counter width constant
- Sub-module pn_lfsr: LFSR_W register with synchronous load (seed, zero-substituted) and shift enable; outputs chip s[0]. Async reset to 1.

## Test plan
- Reset, then seed=10'h001, start, bit_ready=1 -> first preamble chips 1,0,0,0; 31 preamble, 64 payload, 4 zero guard bits; done pulse at transfer 99+1 cycle; busy low after.
- seed=0 -> identical chip stream to seed=1.
- bit_ready toggled randomly during PRE -> chip stream matches golden LFSR model exactly, no repeats or skips; bit_o stable during stalls.
- pay_valid gapped 1-of-3 -> pay_ready mirrors bit_ready only in PAY; 64 payload bits delivered in order.
- abort mid-PAY (transfer 10) with start=1 same cycle -> IDLE next cycle, no done, outputs 0, new start accepted afterwards.
- PN_SCRAMBLE_EN build, pay_bit=0 constant -> payload equals LFSR chips 32..95 of the stream; undefined build -> payload all zeros.
